instr_fetch: RTL

Instruction fetch stage of the core. Holds the program counter, issues word requests to instruction memory, buffers returned words in a small FIFO, and presents each instruction to the control unit with its fields already sliced (opcode, func3, func7, register indices). It sits directly upstream of `ctrl`. Branch and jump redirects from execute flush it and restart fetch at a new PC.

---
 rtl/core_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch.sv | 118 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Definitions shared across the core front end: RV32 major opcodes (instr[6:2]),
// the fetch FSM state type and the default reset vector.
package core_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with a single-cycle flush.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, imem request/response tracking, redirect
// flush with in-flight kill, and a decoded view of the FIFO head for ctrl.
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        illegal
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      tag_q, tag_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] kill_q, kill_d;
    logic [CNT_W-1:0] count;
    logic [63:0]      head;
    logic             pop, accept, rsp_tracked, push;

    assign id_valid = (count != '0);

    always_comb begin
        pop      = id_valid && id_ready;
        // Room is judged after this cycle's pop so a full pipe still issues every cycle.
        imem_req = (state_q == ST_FETCH) &&
                   ((int'(count) + int'(inflight_q) - int'(pop)) < DEPTH);
        accept   = imem_req && imem_ready;
        // A response only counts if we issued it; stale ones after reset are ignored.
        rsp_tracked = imem_rvalid && (inflight_q != '0);
        push        = rsp_tracked && (kill_q == '0) && !redirect;

        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp_tracked);
        tag_d      = accept ? fetch_pc_q : tag_q;

        kill_d = kill_q;
        if (redirect)
            kill_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp_tracked);
        else if (rsp_tracked && (kill_q != '0))
            kill_d = kill_q - 1'b1;

        fetch_pc_d = fetch_pc_q;
        if (redirect)
            fetch_pc_d = word_align(redirect_pc);
        else if (accept)
            fetch_pc_d = fetch_pc_q + 32'd4;

        state_d = state_q;
        case (state_q)
            ST_BOOT:            state_d = ST_FETCH;
            ST_FETCH, ST_DRAIN: state_d = (kill_d != '0) ? ST_DRAIN : ST_FETCH;
            default:            state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= word_align(RESET_PC);
            tag_q      <= '0;
            inflight_q <= '0;
            kill_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({tag_q, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign imem_addr = fetch_pc_q;
    assign pc        = head[63:32];
    assign instr     = head[31:0];
    assign opcode    = instr[6:2];
    assign func3     = instr[14:12];
    assign func7     = instr[31:25];
    assign rd        = instr[11:7];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign illegal   = id_valid && (instr[1:0] != 2'b11);

endmodule
